// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        LAUNCH = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    localparam logic [1:0] BAUD_48  = 2'd0;
    localparam logic [1:0] BAUD_96  = 2'd1;
    localparam logic [1:0] BAUD_192 = 2'd2;
    localparam logic [1:0] BAUD_384 = 2'd3;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; priority starts one past the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     id
);

    int best;
    int best_d;
    int d;

    // Distance d is how far requester j sits after the last winner; smallest wins.
    always_comb begin
        grant  = '0;
        id     = last;
        best   = 0;
        best_d = NUM_REQ;
        d      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j + NUM_REQ - 1 - int'(last)) % NUM_REQ;
            if (enable && req[j] && (d < best_d)) begin
                best_d = d;
                best   = j;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if ((best_d < NUM_REQ) && (best == j)) begin
                grant[j] = 1'b1;
            end
        end
        if (best_d < NUM_REQ) begin
            id = IDW'(best);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx path among several byte producers: fill one burst,
// launch, drain, and apply line configuration only while the link is quiet.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BURST_MAX     = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int DRAIN_TIMEOUT = 65536,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                 SysClk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 cfg_wr,
    input  logic [1:0]           cfg_baud,
    input  logic                 cfg_parity,
    input  logic                 TxFF,
    input  logic                 TxFE,
    input  logic                 tx_busy,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    output logic                 start_Tx,
    output logic [1:0]           baud_selector,
    output logic                 parity_sel,
    output logic [IDW-1:0]       grant_id,
    output logic                 cfg_pending,
    output logic                 drain_err
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT);

    generate
        if ((BURST_MAX < 1) || (BURST_MAX > FIFO_DEPTH)) begin : g_bad_burst
            $error("BURST_MAX must be between 1 and FIFO_DEPTH");
        end
    endgenerate

    sched_state_t       state, next_state;
    logic [BW-1:0]      burst_cnt;
    logic [TW-1:0]      drain_cnt;
    logic [1:0]         baud_shadow;
    logic               parity_shadow;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_id;
    logic               any_grant;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               handshake;
    logic               burst_end;
    logic               drain_done;
    logic               drain_expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .last   (grant_id),
        .enable (state == IDLE),
        .grant  (arb_grant),
        .id     (arb_id)
    );

    assign any_grant = |arb_grant;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == IDW'(j)) begin
                sel_valid    = req_valid[j];
                sel_last     = req_last[j];
                sel_data     = req_data[j*8 +: 8];
                req_ready[j] = (state == FILL) && !TxFF;
            end
        end
    end

    assign handshake     = (state == FILL) && sel_valid && !TxFF;
    assign burst_end     = handshake && (sel_last || (burst_cnt == BW'(BURST_MAX - 1)));
    assign drain_done    = TxFE && !tx_busy;
    assign drain_expired = (drain_cnt == TW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge SysClk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_grant) next_state = FILL;
            FILL:    if (burst_end) next_state = LAUNCH;
            LAUNCH:  next_state = DRAIN;
            DRAIN:   if (drain_done || drain_expired) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Config is applied only in IDLE, where start_Tx is always released.
    always_ff @(posedge SysClk) begin
        if (!rst) begin
            tx_data       <= 8'h00;
            tx_wr         <= 1'b0;
            start_Tx      <= 1'b1;
            baud_selector <= BAUD_96;
            parity_sel    <= PARITY_EVEN;
            grant_id      <= IDW'(NUM_REQ - 1);
            cfg_pending   <= 1'b0;
            drain_err     <= 1'b0;
            burst_cnt     <= '0;
            drain_cnt     <= '0;
            baud_shadow   <= BAUD_96;
            parity_shadow <= PARITY_EVEN;
        end else begin
            tx_wr     <= handshake;
            drain_err <= 1'b0;
            if (handshake) begin
                tx_data <= sel_data;
            end
            case (state)
                IDLE: begin
                    if (cfg_pending) begin
                        baud_selector <= baud_shadow;
                        parity_sel    <= parity_shadow;
                    end
                    if (any_grant) begin
                        grant_id  <= arb_id;
                        burst_cnt <= '0;
                    end
                end
                FILL: begin
                    if (handshake) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    start_Tx  <= 1'b0;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (drain_done) begin
                        start_Tx <= 1'b1;
                    end else if (drain_expired) begin
                        start_Tx  <= 1'b1;
                        drain_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (cfg_wr) begin
                baud_shadow   <= cfg_baud;
                parity_shadow <= cfg_parity;
                cfg_pending   <= 1'b1;
            end else if (state == IDLE) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, single message, fairness,
// config deferral, backpressure and drain timeout.
module tb_uart_tx_scheduler;

    logic        SysClk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        cfg_wr;
    logic [1:0]  cfg_baud;
    logic        cfg_parity;
    logic        TxFF;
    logic        TxFE;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        start_Tx;
    logic [1:0]  baud_selector;
    logic        parity_sel;
    logic [1:0]  grant_id;
    logic        cfg_pending;
    logic        drain_err;

    uart_tx_scheduler #(
        .NUM_REQ(4), .BURST_MAX(4), .FIFO_DEPTH(16), .DRAIN_TIMEOUT(100)
    ) dut (
        .SysClk(SysClk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
        .TxFF(TxFF), .TxFE(TxFE), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_wr(tx_wr), .start_Tx(start_Tx),
        .baud_selector(baud_selector), .parity_sel(parity_sel),
        .grant_id(grant_id), .cfg_pending(cfg_pending), .drain_err(drain_err)
    );

    always #5 SysClk = ~SysClk;

    int tests = 0;
    int fails = 0;

    logic [7:0] msg [4][8];
    int         mlen [4];
    int         ptr [4];
    logic [3:0] hs;
    logic [3:0] last_ready;
    logic       prev_start;
    int         hs_since;
    int         low_cnt;
    int         err_cnt;
    logic [7:0] wr_q [$];
    logic [7:0] exp_q [$];
    int         burst_len_q [$];
    int         burst_src_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive requesters, sample ready before the edge, log after it.
    task automatic applyStimulus();
        for (int r = 0; r < 4; r++) begin
            if (ptr[r] < mlen[r]) begin
                req_valid[r]         = 1'b1;
                req_data[r*8 +: 8]   = msg[r][ptr[r]];
                req_last[r]          = (ptr[r] == mlen[r] - 1);
            end else begin
                req_valid[r]         = 1'b0;
                req_data[r*8 +: 8]   = 8'h00;
                req_last[r]          = 1'b0;
            end
        end
        #3;
        last_ready = req_ready;
        hs = req_valid & req_ready;
        @(posedge SysClk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (hs[r]) begin
                ptr[r]++;
                hs_since++;
            end
        end
        if (tx_wr) wr_q.push_back(tx_data);
        if (!start_Tx) low_cnt++;
        if (drain_err) err_cnt++;
        if (prev_start && !start_Tx) begin
            burst_len_q.push_back(hs_since);
            burst_src_q.push_back(int'(grant_id));
            hs_since = 0;
        end
        prev_start = start_Tx;
    endtask

    task automatic loadMsg(input int r, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) msg[r][i] = base + 8'(i);
        mlen[r] = len;
        ptr[r]  = 0;
    endtask

    task automatic clearLogs();
        wr_q.delete();
        exp_q.delete();
        burst_len_q.delete();
        burst_src_q.delete();
        hs_since = 0;
        low_cnt  = 0;
        err_cnt  = 0;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) checkOutput({tag, "_byte"}, 32'(wr_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       got;
        logic [3:0] rdy_or;
        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        cfg_wr = 1'b0; cfg_baud = 2'd0; cfg_parity = 1'b0;
        TxFF = 1'b0; TxFE = 1'b1; tx_busy = 1'b0;
        prev_start = 1'b1;
        for (int r = 0; r < 4; r++) begin mlen[r] = 0; ptr[r] = 0; end
        clearLogs();
        @(posedge SysClk);
        #1;

        // Reset
        repeat (3) applyStimulus();
        checkOutput("rst_start_Tx", 32'(start_Tx), 32'd1);
        checkOutput("rst_baud", 32'(baud_selector), 32'd1);
        checkOutput("rst_parity", 32'(parity_sel), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_tx_wr", 32'(tx_wr), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd3);
        checkOutput("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        checkOutput("rst_drain_err", 32'(drain_err), 32'd0);
        rst = 1'b1;
        applyStimulus();

        // Single message from requester 0
        clearLogs();
        msg[0][0] = 8'h55; msg[0][1] = 8'hE5; msg[0][2] = 8'hFF;
        mlen[0] = 3; ptr[0] = 0;
        applyStimulus();
        checkOutput("single_ready_in_idle", 32'(last_ready), 32'd0);
        checkOutput("single_grant", 32'(grant_id), 32'd0);
        applyStimulus();
        checkOutput("single_first_ready", 32'(last_ready), 32'd1);
        repeat (12) applyStimulus();
        exp_q = '{8'h55, 8'hE5, 8'hFF};
        checkWrites("single_wr");
        checkOutput("single_low_cycles", 32'(low_cnt), 32'd1);
        checkOutput("single_bursts", 32'(burst_len_q.size()), 32'd1);
        checkOutput("single_end_start_Tx", 32'(start_Tx), 32'd1);

        // Fairness between requesters 1 and 3 with 6-byte messages
        clearLogs();
        loadMsg(1, 6, 8'h10);
        loadMsg(3, 6, 8'h30);
        repeat (40) applyStimulus();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33,
                  8'h14, 8'h15, 8'h34, 8'h35};
        checkWrites("fair_wr");
        checkOutput("fair_bursts", 32'(burst_len_q.size()), 32'd4);
        if (burst_len_q.size() == 4) begin
            checkOutput("fair_len0", 32'(burst_len_q[0]), 32'd4);
            checkOutput("fair_len1", 32'(burst_len_q[1]), 32'd4);
            checkOutput("fair_len2", 32'(burst_len_q[2]), 32'd2);
            checkOutput("fair_len3", 32'(burst_len_q[3]), 32'd2);
            checkOutput("fair_src0", 32'(burst_src_q[0]), 32'd1);
            checkOutput("fair_src1", 32'(burst_src_q[1]), 32'd3);
            checkOutput("fair_src2", 32'(burst_src_q[2]), 32'd1);
            checkOutput("fair_src3", 32'(burst_src_q[3]), 32'd3);
        end

        // Config written during DRAIN is held until the first IDLE cycle
        clearLogs();
        tx_busy = 1'b1;
        loadMsg(0, 1, 8'h3C);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus();
            if (!start_Tx) got = 1'b1;
        end
        checkOutput("cfg_reached_drain", 32'(got), 32'd1);
        cfg_wr = 1'b1; cfg_baud = 2'd2; cfg_parity = 1'b1;
        applyStimulus();
        cfg_wr = 1'b0;
        checkOutput("cfg_pending_set", 32'(cfg_pending), 32'd1);
        checkOutput("cfg_baud_held", 32'(baud_selector), 32'd1);
        repeat (3) applyStimulus();
        checkOutput("cfg_baud_held_drain", 32'(baud_selector), 32'd1);
        checkOutput("cfg_parity_held_drain", 32'(parity_sel), 32'd0);
        tx_busy = 1'b0;
        applyStimulus();
        checkOutput("cfg_drain_exit", 32'(start_Tx), 32'd1);
        checkOutput("cfg_baud_exit", 32'(baud_selector), 32'd1);
        checkOutput("cfg_pending_exit", 32'(cfg_pending), 32'd1);
        applyStimulus();
        checkOutput("cfg_baud_applied", 32'(baud_selector), 32'd2);
        checkOutput("cfg_parity_applied", 32'(parity_sel), 32'd1);
        checkOutput("cfg_pending_clear", 32'(cfg_pending), 32'd0);
        repeat (3) applyStimulus();

        // Backpressure from a full FIFO mid-burst
        clearLogs();
        loadMsg(2, 6, 8'hA0);
        repeat (3) applyStimulus();
        checkOutput("bp_pre_writes", 32'(wr_q.size()), 32'd2);
        TxFF = 1'b1;
        rdy_or = '0;
        repeat (5) begin
            applyStimulus();
            rdy_or = rdy_or | last_ready;
        end
        checkOutput("bp_ready_low", 32'(rdy_or), 32'd0);
        checkOutput("bp_no_writes", 32'(wr_q.size()), 32'd2);
        TxFF = 1'b0;
        repeat (25) applyStimulus();
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        checkWrites("bp_wr");
        checkOutput("bp_bursts", 32'(burst_len_q.size()), 32'd2);
        if (burst_len_q.size() == 2) begin
            checkOutput("bp_len0", 32'(burst_len_q[0]), 32'd4);
            checkOutput("bp_len1", 32'(burst_len_q[1]), 32'd2);
        end

        // Drain timeout with the serializer stuck busy
        clearLogs();
        tx_busy = 1'b1;
        loadMsg(3, 1, 8'hC3);
        loadMsg(1, 1, 8'h1B);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            applyStimulus();
            if (drain_err) got = 1'b1;
        end
        checkOutput("to_seen", 32'(got), 32'd1);
        checkOutput("to_low_cycles", 32'(low_cnt), 32'd100);
        checkOutput("to_start_Tx", 32'(start_Tx), 32'd1);
        checkOutput("to_first_src", 32'(burst_src_q.size() > 0 ? burst_src_q[0] : -1), 32'd3);
        applyStimulus();
        checkOutput("to_err_pulse", 32'(drain_err), 32'd0);
        checkOutput("to_next_grant", 32'(grant_id), 32'd1);
        tx_busy = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("to_err_count", 32'(err_cnt), 32'd1);
        exp_q = '{8'hC3, 8'h1B};
        checkWrites("to_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Arbitrates between several byte producers sharing a single UART transmit path, and sequences that path through a fixed cycle: fill the Tx FIFO with one burst, launch serialization, then wait for the FIFO and serializer to drain. It also owns the line configuration (baud select, parity) and changes it only while the link is quiet. It sits between client logic and `UART_TOP`, driving `data_in`, `start_Tx`, `baud_selector` and `parity_sel`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BURST_MAX, 4, max bytes granted per burst; must be ≤ FIFO_DEPTH
- FIFO_DEPTH, 16, Tx FIFO depth; used only to check BURST_MAX at elaboration
- DRAIN_TIMEOUT, 65536, SysClk cycles allowed in DRAIN before abort

Ports:
- SysClk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ×8  per-requester byte
- req_last  in  NUM_REQ  marks the final byte of a requester's message
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- cfg_wr  in  1  one-cycle strobe that captures new config
- cfg_baud  in  2  requested baud code
- cfg_parity  in  1  requested parity (0 even, 1 odd)
- TxFF  in  1  Tx FIFO full
- TxFE  in  1  Tx FIFO empty
- tx_busy  in  1  serializer shifting a frame
- tx_data  out  8  byte to Tx FIFO (`data_in`)
- tx_wr  out  1  Tx FIFO write strobe
- start_Tx  out  1  active-low transmit enable
- baud_selector  out  2  applied baud code
- parity_sel  out  1  applied parity
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- cfg_pending  out  1  captured config not yet applied
- drain_err  out  1  one-cycle pulse on DRAIN timeout

## Operation
- States: IDLE, FILL, LAUNCH, DRAIN.
- IDLE:
  - Apply pending config, if any: outputs update and cfg_pending clears on the same edge.
  - Then, if any req_valid is set, grant by round-robin starting at grant_id+1 (mod NUM_REQ), then go to FILL.
  - Config apply and grant can occur in the same cycle.
- FILL:
  - req_ready[grant_id] = !TxFF; all other ready bits are 0.
  - Each handshake increments the burst counter and produces a registered FIFO write.
  - Exit to LAUNCH after a handshake with req_last=1, or when the count reaches BURST_MAX.
  - A valid drop is a stall, not an exit.
- LAUNCH: drive start_Tx=0, go to DRAIN.
- DRAIN:
  - Hold start_Tx=0 until TxFE=1 and tx_busy=0 in the same cycle; then set start_Tx=1 and go to IDLE.
  - If the timeout counter reaches DRAIN_TIMEOUT-1: pulse drain_err, set start_Tx=1, go to IDLE.
- cfg_wr in any state overwrites the shadow register and sets cfg_pending. The last write wins.
- A requester cut off by BURST_MAX keeps its remaining bytes until its next grant.

## Timing
- Reset values:
  - state IDLE, start_Tx=1, tx_wr=0, tx_data=0
  - req_ready=0, baud_selector=2'd1, parity_sel=0
  - grant_id=NUM_REQ-1, so requester 0 wins first
  - cfg_pending=0, drain_err=0, counters 0
- Reset mid-burst: drops the FIFO write in flight and releases start_Tx on the next edge.
- Handshake at edge N → tx_wr=1 with tx_data at edge N+1, one cycle wide.
- Timing from a valid request in IDLE:
  - Request present at edge N → FILL at N+1.
  - First req_ready at cycle N+1.
  - Minimum gap from last byte to start_Tx=0 is 1 cycle (LAUNCH).
- Back-to-back handshakes give one FIFO write per cycle.
- TxFF=1 forces ready low in the same cycle (combinational).
- baud_selector and parity_sel never change while start_Tx=0.

## Structure
- Package `uart_ctrl_pkg` holds:
  - state enum `sched_state_t`
  - baud codes BAUD_48=0, BAUD_96=1, BAUD_192=2, BAUD_384=3
  - parity constants
- One sub-module, `rr_arbiter`:
  - Parameter: NUM_REQ.
  - Inputs: request vector, last-grant pointer, enable.
  - Outputs: one-hot grant and encoded id.
  - Purely combinational.
- The FSM, counters, config shadow and output registers stay in the top level.

## Test plan
- Reset: hold rst=0 for 3 cycles → start_Tx=1, baud_selector=1, parity_sel=0, req_ready=0.
- Single message: req0 sends 0x55, 0xE5, 0xFF (last on 0xFF) → exactly 3 tx_wr pulses with those values in order, then start_Tx=0 for one full drain (TxFE=1, tx_busy=0 model), then start_Tx=1 and IDLE.
- Fairness: req1 and req3 continuously valid with 6-byte messages, BURST_MAX=4 → grant sequence 1,3,1,3, burst lengths 4,4,2,2.
- Config: cfg_wr with cfg_baud=2 during DRAIN → baud_selector stays 1 until the first IDLE cycle, then becomes 2; cfg_pending 1→0 on that edge.
- Backpressure: TxFF=1 for 5 cycles mid-FILL → req_ready=0, no tx_wr; byte count unchanged after release.
- Timeout: DRAIN_TIMEOUT=100, tx_busy stuck at 1 → drain_err pulses at cycle 100 of DRAIN, start_Tx=1, next requester granted.
